// File: rtl/mc_alu.sv
// Multi-cycle execute-stage ALU: single-cycle add/sub/logic, WIDTH-cycle iterative
// multiply (MUL/MLA/MLS) and restoring divide, with a start/busy/done handshake.
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic             carry_in_i,
    input  logic             use_carry_i,
    input  logic             saturate_i,
    input  logic             is_unsigned_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [4:0]       flags_o,
    output logic             div0_o
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORR = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_RSB = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_MLA = 4'd7;
    localparam logic [3:0] OP_MLS = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, c_q, md_q, hi_q, lo_q;
    logic               uns_q, a_neg_q, b_neg_q, b_zero_q;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic [4:0]         flags_q;
    logic               div0_q, busy_q, done_q;

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign flags_o     = flags_q;
    assign div0_o      = div0_q;

    // Single-cycle path works straight off the inputs on the accepting edge.
    logic [WIDTH-1:0] alu_x, alu_y, alu_res;
    logic [WIDTH:0]   alu_sum;
    logic             alu_cin, alu_add, alu_v, alu_sat;
    logic [4:0]       alu_flags;

    always_comb begin
        alu_x   = a_i;
        alu_y   = b_i;
        alu_cin = 1'b0;
        alu_add = 1'b0;
        case (op_i)
            OP_ADD: begin
                alu_add = 1'b1;
                alu_cin = use_carry_i ? carry_in_i : 1'b0;
            end
            OP_SUB: begin
                alu_add = 1'b1;
                alu_y   = ~b_i;
                alu_cin = use_carry_i ? carry_in_i : 1'b1;
            end
            OP_RSB: begin
                alu_add = 1'b1;
                alu_x   = ~a_i;
                alu_cin = use_carry_i ? carry_in_i : 1'b1;
            end
            default: ;
        endcase
        alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {{WIDTH{1'b0}}, alu_cin};
        alu_v   = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_x[WIDTH-1]);
        alu_sat = alu_add && alu_v && saturate_i;
        case (op_i)
            OP_ADD, OP_SUB, OP_RSB:
                alu_res = alu_sat ? (alu_sum[WIDTH-1] ? SAT_POS : SAT_NEG) : alu_sum[WIDTH-1:0];
            OP_AND:  alu_res = a_i & b_i;
            OP_ORR:  alu_res = a_i | b_i;
            OP_EOR:  alu_res = a_i ^ b_i;
            default: alu_res = '0;
        endcase
        alu_flags = {alu_sat, alu_res[WIDTH-1], alu_res == '0,
                     alu_add & alu_sum[WIDTH], alu_add & alu_v};
    end

    // Long ops iterate on magnitudes; signs are re-applied at completion.
    logic             a_neg, b_neg, op_long;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg   = !is_unsigned_i && a_i[WIDTH-1];
        b_neg   = !is_unsigned_i && b_i[WIDTH-1];
        a_mag   = a_neg ? -a_i : a_i;
        b_mag   = b_neg ? -b_i : b_i;
        op_long = (op_i == OP_MUL) || (op_i == OP_MLA) || (op_i == OP_MLS) || (op_i == OP_DIV);
    end

    // hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
    logic             is_div, div_ge;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_diff, hi_d, lo_d;

    always_comb begin
        is_div   = (op_q == OP_DIV);
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, md_q};
        div_diff = div_sh[WIDTH-1:0] - md_q;
        if (is_div) begin
            hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] raw, prod_s, c_ext, long_res;
    logic [WIDTH-1:0]   div_q, div_r;
    logic               res_neg;
    logic [4:0]         long_flags;

    always_comb begin
        raw     = {hi_d, lo_d};
        res_neg = a_neg_q ^ b_neg_q;
        prod_s  = res_neg ? -raw : raw;
        c_ext   = uns_q ? {{WIDTH{1'b0}}, c_q} : {{WIDTH{c_q[WIDTH-1]}}, c_q};
        div_q   = res_neg ? -lo_d : lo_d;
        div_r   = a_neg_q ? -hi_d : hi_d;
        case (op_q)
            OP_MUL:  long_res = prod_s;
            OP_MLA:  long_res = c_ext + prod_s;
            OP_MLS:  long_res = c_ext - prod_s;
            OP_DIV:  long_res = b_zero_q ? {a_q, {WIDTH{1'b0}}} : {div_r, div_q};
            default: long_res = raw;
        endcase
        long_flags = {1'b0, long_res[2*WIDTH-1], long_res == '0, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            op_q        <= '0;
            a_q         <= '0;
            c_q         <= '0;
            md_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            uns_q       <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            div0_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    op_q     <= op_i;
                    a_q      <= a_i;
                    c_q      <= c_i;
                    uns_q    <= is_unsigned_i;
                    a_neg_q  <= a_neg;
                    b_neg_q  <= b_neg;
                    b_zero_q <= (b_i == '0);
                    busy_q   <= 1'b1;
                    if (op_long) begin
                        hi_q    <= '0;
                        lo_q    <= (op_i == OP_DIV) ? a_mag : b_mag;
                        md_q    <= (op_i == OP_DIV) ? b_mag : a_mag;
                        count_q <= CW'(WIDTH);
                        state_q <= RUN;
                    end else begin
                        result_q    <= alu_res;
                        result_hi_q <= '0;
                        flags_q     <= alu_flags;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                RUN: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q - CW'(1);
                    // Last iteration folds straight into sign fix-up and accumulate.
                    if (count_q == CW'(1)) begin
                        result_q    <= long_res[WIDTH-1:0];
                        result_hi_q <= long_res[2*WIDTH-1:WIDTH];
                        flags_q     <= long_flags;
                        if (is_div) div0_q <= b_zero_q;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
